// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode constants and 2-bit counter encodings
// shared by the branch predictor and the control unit
package cpu_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: next-state function of a 2-bit
// saturating up/down counter
import cpu_pkg::*;

module sat_counter2 (
  input  logic [1:0] cnt,
  input  logic       up,
  output logic [1:0] nxt
);

  logic at_max;
  logic at_min;

  assign at_max = (cnt == CNT_ST);
  assign at_min = (cnt == CNT_SNT);

  always_comb begin
    nxt = cnt;
    unique case (1'b1)
      (up && !at_max): nxt = cnt + 2'd1;
      (!up && !at_min): nxt = cnt - 2'd1;
      default: nxt = cnt;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit counter table, IF lookup, ID train
// define BP_GSHARE_EN to xor a global history into the index
import cpu_pkg::*;

module branch_predictor #(
  parameter int         INDEX_BITS = 6,
  parameter int         PC_WIDTH   = 32,
  parameter logic [1:0] CNT_RESET  = 2'b01
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                enable,
  input  logic [PC_WIDTH-1:0] if_pc,
  input  logic [6:0]          if_opcode,
  output logic                if_predict_taken,
  input  logic                id_flush,
  output logic                id_branch_taken,
  input  logic                id_reg_equal,
  output logic                id_mispredict
);

  localparam int N = 1 << INDEX_BITS;

  typedef logic [INDEX_BITS-1:0] idx_t;

  logic [1:0] cnt [N];
  logic [1:0] cnt_nxt;
  idx_t       pc_idx;
  idx_t       if_idx;
  idx_t       id_idx;
  logic       if_is_branch;
  logic       id_is_branch;
  logic       id_pred;
  logic       train;
  logic       unused_pc;

  assign pc_idx = if_pc[INDEX_BITS+1:2];
  assign unused_pc = ^{if_pc[PC_WIDTH-1:INDEX_BITS+2],
                       if_pc[1:0]};

  assign if_is_branch = (if_opcode == OP_BRANCH);
  assign train = enable & id_is_branch;

`ifdef BP_GSHARE_EN
  idx_t ghr;

  assign if_idx = pc_idx ^ ghr;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ghr <= '0;
    end else if (train) begin
      ghr <= {ghr[INDEX_BITS-2:0], id_reg_equal};
    end
  end
`else
  assign if_idx = pc_idx;
`endif

  // lookup sees the pre-update value on a same-entry write
  assign if_predict_taken = if_is_branch & cnt[if_idx][1];

  assign id_branch_taken = id_pred;
  assign id_mispredict = id_is_branch &
                         (id_reg_equal != id_pred);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      id_is_branch <= 1'b0;
      id_pred      <= 1'b0;
      id_idx       <= '0;
    end else if (enable) begin
      id_idx <= if_idx;
      if (id_flush) begin
        id_is_branch <= 1'b0;
        id_pred      <= 1'b0;
      end else begin
        id_is_branch <= if_is_branch;
        id_pred      <= if_predict_taken;
      end
    end
  end

  sat_counter2 u_cnt (
    .cnt (cnt[id_idx]),
    .up  (id_reg_equal),
    .nxt (cnt_nxt)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < N; i++) begin
        cnt[i] <= CNT_RESET;
      end
    end else if (train) begin
      cnt[id_idx] <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors against a
// behavioural counter-table model
import cpu_pkg::*;

module tb_branch_predictor;

  localparam int IB = 6;
  localparam int NE = 1 << IB;
  localparam logic [6:0] BR  = OP_BRANCH;
  localparam logic [6:0] NOP = OP_IMM;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] if_pc = '0;
  logic [6:0]  if_opcode = '0;
  logic        id_flush = 1'b0;
  logic        id_reg_equal = 1'b0;
  logic        if_predict_taken;
  logic        id_branch_taken;
  logic        id_mispredict;

  int checks = 0;
  int failures = 0;
  bit run = 1'b1;

  int m_cnt [NE];
  bit m_br;
  bit m_pred;
  int m_idx;
  int m_ghr;

  always #5 clk = ~clk;

  branch_predictor #(
    .INDEX_BITS (IB),
    .PC_WIDTH   (32),
    .CNT_RESET  (2'b01)
  ) dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .enable           (enable),
    .if_pc            (if_pc),
    .if_opcode        (if_opcode),
    .if_predict_taken (if_predict_taken),
    .id_flush         (id_flush),
    .id_branch_taken  (id_branch_taken),
    .id_reg_equal     (id_reg_equal),
    .id_mispredict    (id_mispredict)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // hand-computed values assume plain PC indexing
  task automatic lit(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
`ifndef BP_GSHARE_EN
    chk(nm, act, exp);
`endif
  endtask

  function automatic int lidx(input logic [31:0] pc);
    int i;
    i = int'(pc[IB+1:2]);
`ifdef BP_GSHARE_EN
    i = i ^ m_ghr;
`endif
    return i;
  endfunction

  function automatic bit exp_if();
    return (if_opcode == BR) && (m_cnt[lidx(if_pc)] >= 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) m_cnt[i] = 1;
    m_br = 1'b0;
    m_pred = 1'b0;
    m_idx = 0;
    m_ghr = 0;
  endtask

  always @(negedge clk) begin
    #2;
    if (run) begin
      chk("if_pred", if_predict_taken, exp_if());
      chk("id_bt", id_branch_taken, m_pred);
      chk("id_mis", id_mispredict,
          m_br && (id_reg_equal != m_pred));
    end
  end

  task automatic drive(input logic [31:0] pc,
                       input logic [6:0] op,
                       input logic fl,
                       input logic en,
                       input logic req);
    @(negedge clk);
    if_pc = pc;
    if_opcode = op;
    id_flush = fl;
    enable = en;
    id_reg_equal = req;
    #3;
  endtask

  task automatic tick();
    int li;
    bit lp;
    @(posedge clk);
    if (enable) begin
      li = lidx(if_pc);
      lp = (if_opcode == BR) && (m_cnt[li] >= 2);
      if (m_br) begin
        if (id_reg_equal)
          m_cnt[m_idx] = (m_cnt[m_idx] == 3) ? 3 : m_cnt[m_idx] + 1;
        else
          m_cnt[m_idx] = (m_cnt[m_idx] == 0) ? 0 : m_cnt[m_idx] - 1;
        m_ghr = ((m_ghr << 1) | int'(id_reg_equal)) % NE;
      end
      if (id_flush) begin
        m_br = 1'b0;
        m_pred = 1'b0;
      end else begin
        m_br = (if_opcode == BR);
        m_pred = lp;
        m_idx = li;
      end
    end
  endtask

  task automatic step(input logic [31:0] pc,
                      input logic [6:0] op,
                      input logic fl,
                      input logic en,
                      input logic req);
    drive(pc, op, fl, en, req);
    tick();
  endtask

  task automatic do_reset();
    enable = 1'b0;
    id_flush = 1'b0;
    arst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #3;
    arst_n = 1'b1;
  endtask

  logic [31:0] pcs [6];

  initial begin
    pcs = '{32'h0, 32'h4, 32'h100, 32'hfc, 32'h40, 32'h1040};
    do_reset();

    drive(32'h40, BR, 0, 1, 0);
    chk("rst_if", if_predict_taken, 1'b0);
    chk("rst_bt", id_branch_taken, 1'b0);
    chk("rst_mis", id_mispredict, 1'b0);
    tick();
    drive(32'h44, NOP, 0, 1, 1);
    lit("first_mis", id_mispredict, 1'b1);
    lit("first_bt", id_branch_taken, 1'b0);
    tick();
    lit("cnt16_wt", m_cnt[16], 2);
    drive(32'h40, BR, 0, 1, 0);
    lit("tk2_if", if_predict_taken, 1'b1);
    tick();
    drive(32'h44, NOP, 0, 1, 1);
    lit("tk2_mis", id_mispredict, 1'b0);
    tick();
    drive(32'h40, BR, 0, 1, 0);
    lit("tk3_if", if_predict_taken, 1'b1);
    tick();
    step(32'h44, NOP, 0, 1, 1);
    lit("cnt16_sat", m_cnt[16], 3);

    step(32'h40, BR, 0, 1, 0);
    drive(32'h44, NOP, 0, 1, 0);
    lit("nt1_mis", id_mispredict, 1'b1);
    tick();
    drive(32'h40, BR, 0, 1, 0);
    lit("nt1_if", if_predict_taken, 1'b1);
    tick();
    step(32'h44, NOP, 0, 1, 0);
    drive(32'h40, BR, 0, 1, 0);
    lit("nt2_if", if_predict_taken, 1'b0);
    tick();

    repeat (3) begin
      drive(32'h48, NOP, 0, 0, 1);
      lit("stall_bt", id_branch_taken, 1'b0);
      lit("stall_mis", id_mispredict, 1'b1);
      tick();
    end
    step(32'h48, NOP, 0, 1, 1);
    drive(32'h40, BR, 0, 1, 0);
    lit("stall_if", if_predict_taken, 1'b1);
    tick();
    step(32'h44, NOP, 0, 1, 0);
    drive(32'h40, BR, 0, 1, 0);
    lit("stall_once", if_predict_taken, 1'b0);
    tick();
    step(32'h44, NOP, 0, 1, 1);

    step(32'h40, BR, 1, 1, 0);
    drive(32'h44, NOP, 0, 1, 1);
    lit("fl_bt", id_branch_taken, 1'b0);
    lit("fl_mis", id_mispredict, 1'b0);
    tick();
    drive(32'h40, OP_JAL, 0, 1, 0);
    lit("jal_if", if_predict_taken, 1'b0);
    tick();
    drive(32'h40, BR, 0, 1, 1);
    lit("fl_keep", if_predict_taken, 1'b1);
    tick();
    drive(32'h44, NOP, 0, 1, 1);
    do_reset();
    drive(32'h40, BR, 0, 1, 0);
    chk("rst2_if", if_predict_taken, 1'b0);
    tick();
    step(32'h44, NOP, 0, 1, 0);

    do_reset();
    step(32'h40, BR, 0, 1, 0);
    step(32'h44, NOP, 0, 1, 1);
    drive(32'h140, BR, 0, 1, 0);
`ifdef BP_GSHARE_EN
    chk("alias_if", if_predict_taken, 1'b0);
`else
    chk("alias_if", if_predict_taken, 1'b1);
`endif
    tick();
    step(32'h144, NOP, 0, 1, 0);

    for (int i = 0; i < 6; i++) begin
      repeat (3) begin
        step(pcs[i], BR, 0, 1, 0);
        step(pcs[i] + 32'h4, NOP, 0, 1, logic'(i % 2));
      end
    end

    step(32'h200, NOP, 0, 1, 0);
    run = 1'b0;
    #20;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
